// File: rtl/aes_core_arbiter.sv
// Two-requester round-robin front end that shares one AES core (key expansion + cipher/decipher).
// Define AES_ARB_KEY_CACHE_EN to skip key expansion when the cached key tag and size still match.
module aes_core_arbiter #(
  parameter int unsigned KEY_ID_BITS = 4,
  parameter int unsigned NUM_REQ     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_decrypt,
  input  logic [NUM_REQ-1:0]               req_aes256,
  input  logic [256*NUM_REQ-1:0]           req_key,
  input  logic [NUM_REQ*KEY_ID_BITS-1:0]   req_key_id,
  input  logic [128*NUM_REQ-1:0]           req_blk,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [127:0]                     rsp_blk,
  input  logic                             key_flush,
  output logic                             aes_alg_en_key,
  output logic                             aes_alg_en_cipher,
  output logic                             aes_alg_en_decipher,
  output logic                             aes128_mode,
  output logic                             aes256_mode,
  output logic [255:0]                     aes_alg_key,
  output logic [127:0]                     aes_alg_in_blk,
  input  logic [127:0]                     aes_alg_out_blk,
  input  logic                             aes_op_in_progress,
  input  logic                             aes_alg_done
);

  typedef enum logic [2:0] {
    StIdle,
    StKeyStart,
    StKeyWait,
    StOpStart,
    StOpWait,
    StResp
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Latched request and arbitration state
  logic                   r_grant;
  logic                   r_last;
  logic                   r_decrypt;
  logic                   r_aes256;
  logic [255:0]           r_key;
  logic [KEY_ID_BITS-1:0] r_key_id;
  logic [127:0]           r_blk;
  logic [127:0]           r_rsp_blk;
  logic                   r_mode_128;
  logic                   r_mode_256;

  // Record of the key currently expanded inside the core
  logic                   r_cache_valid;
  logic                   r_cache_aes256;
  logic [KEY_ID_BITS-1:0] r_cache_id;

  logic                   w_pick;
  logic                   w_grant;
  logic                   w_resp_ack;
  logic                   w_need_key;
  logic                   w_cache_miss;
  logic                   w_cache_bypass;
  logic                   w_sel_decrypt;
  logic                   w_sel_aes256;
  logic [255:0]           w_sel_key;
  logic [KEY_ID_BITS-1:0] w_sel_key_id;
  logic [127:0]           w_sel_blk;

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    if (req_valid[0] && req_valid[1]) begin
      w_pick = ~r_last;
    end else begin
      w_pick = req_valid[1];
    end
  end

  assign w_sel_decrypt = req_decrypt[w_pick];
  assign w_sel_aes256  = req_aes256[w_pick];
  assign w_sel_key     = w_pick ? req_key[256 +: 256] : req_key[0 +: 256];
  assign w_sel_key_id  = w_pick ? req_key_id[KEY_ID_BITS +: KEY_ID_BITS]
                                : req_key_id[0 +: KEY_ID_BITS];
  assign w_sel_blk     = w_pick ? req_blk[128 +: 128] : req_blk[0 +: 128];

  assign w_grant    = (r_state == StIdle) && !reset && !aes_op_in_progress && (|req_valid);
  assign w_resp_ack = (r_state == StResp) && rsp_ready[r_grant];

  // A flush in the grant cycle forces expansion even if the tag still matches.
  assign w_cache_miss = key_flush || !r_cache_valid || (r_cache_id != w_sel_key_id) ||
                        (r_cache_aes256 != w_sel_aes256);

`ifdef AES_ARB_KEY_CACHE_EN
  assign w_cache_bypass = 1'b0;
`else
  assign w_cache_bypass = 1'b1;
`endif

  assign w_need_key = w_cache_bypass || w_cache_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_next = w_need_key ? StKeyStart : StOpStart;
        end
      end
      StKeyStart: w_state_next = StKeyWait;
      StKeyWait: begin
        if (aes_alg_done) begin
          w_state_next = StOpStart;
        end
      end
      StOpStart: w_state_next = StOpWait;
      StOpWait: begin
        if (aes_alg_done) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (w_resp_ack) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready           = '0;
    rsp_valid           = '0;
    aes_alg_en_key      = 1'b0;
    aes_alg_en_cipher   = 1'b0;
    aes_alg_en_decipher = 1'b0;
    if (w_grant) begin
      req_ready[w_pick] = 1'b1;
    end
    unique case (r_state)
      StKeyStart: aes_alg_en_key = 1'b1;
      StOpStart: begin
        aes_alg_en_cipher   = !r_decrypt;
        aes_alg_en_decipher = r_decrypt;
      end
      StResp:  rsp_valid[r_grant] = 1'b1;
      default: ;
    endcase
  end

  assign aes_alg_key    = r_key;
  assign aes_alg_in_blk = r_blk;
  assign aes128_mode    = r_mode_128;
  assign aes256_mode    = r_mode_256;
  assign rsp_blk        = r_rsp_blk;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_decrypt  <= 1'b0;
      r_aes256   <= 1'b0;
      r_key      <= '0;
      r_key_id   <= '0;
      r_blk      <= '0;
      r_rsp_blk  <= '0;
      r_mode_128 <= 1'b0;
      r_mode_256 <= 1'b0;
    end else begin
      if (w_grant) begin
        r_grant   <= w_pick;
        r_decrypt <= w_sel_decrypt;
        r_aes256  <= w_sel_aes256;
        r_key     <= w_sel_key;
        r_key_id  <= w_sel_key_id;
        r_blk     <= w_sel_blk;
        // Mode bits only change with a new expansion so a cached key keeps its size.
        if (w_need_key) begin
          r_mode_128 <= !w_sel_aes256;
          r_mode_256 <= w_sel_aes256;
        end
      end
      if ((r_state == StOpWait) && aes_alg_done) begin
        r_rsp_blk <= aes_alg_out_blk;
      end
      if (w_resp_ack) begin
        r_last <= r_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cache_valid  <= 1'b0;
      r_cache_aes256 <= 1'b0;
      r_cache_id     <= '0;
    end else if (key_flush) begin
      r_cache_valid <= 1'b0;
    end else if ((r_state == StKeyWait) && aes_alg_done) begin
      r_cache_valid  <= 1'b1;
      r_cache_aes256 <= r_aes256;
      r_cache_id     <= r_key_id;
    end
  end

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_op_strobe_excl: assert property (@(posedge clk) disable iff (reset)
                                     !(aes_alg_en_cipher && aes_alg_en_decipher));
  a_grant_only_idle: assert property (@(posedge clk) disable iff (reset)
                                      (req_ready != '0) |-> (r_state == StIdle));

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: a behavioural AES core stand-in, a response scoreboard,
// a vector table and hand-written sequences for round-robin, key reuse, reset and back-pressure.
module tb_aes_core_arbiter;

  localparam int unsigned KB   = 4;
  localparam int unsigned KLAT = 6;
  localparam int unsigned OLAT = 5;
  localparam logic [255:0] K_FIPS = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K3 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K4 = {128'hf00dfeed0123456789abcdef55aa33cc, 128'h0};
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

`ifdef AES_ARB_KEY_CACHE_EN
  localparam int unsigned SAME_ID_EXPANSIONS = 1;
`else
  localparam int unsigned SAME_ID_EXPANSIONS = 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid, req_ready, req_decrypt, req_aes256;
  logic [511:0]   req_key;
  logic [2*KB-1:0] req_key_id;
  logic [255:0]   req_blk;
  logic [1:0]     rsp_valid, rsp_ready;
  logic [127:0]   rsp_blk;
  logic           key_flush;
  logic           aes_alg_en_key, aes_alg_en_cipher, aes_alg_en_decipher;
  logic           aes128_mode, aes256_mode;
  logic [255:0]   aes_alg_key;
  logic [127:0]   aes_alg_in_blk;
  logic [127:0]   aes_alg_out_blk = '0;
  logic           aes_op_in_progress;
  logic           aes_alg_done = 1'b0;

  always #5 clk = ~clk;

  aes_core_arbiter #(
    .KEY_ID_BITS(KB),
    .NUM_REQ    (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_decrypt        (req_decrypt),
    .req_aes256         (req_aes256),
    .req_key            (req_key),
    .req_key_id         (req_key_id),
    .req_blk            (req_blk),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_blk            (rsp_blk),
    .key_flush          (key_flush),
    .aes_alg_en_key     (aes_alg_en_key),
    .aes_alg_en_cipher  (aes_alg_en_cipher),
    .aes_alg_en_decipher(aes_alg_en_decipher),
    .aes128_mode        (aes128_mode),
    .aes256_mode        (aes256_mode),
    .aes_alg_key        (aes_alg_key),
    .aes_alg_in_blk     (aes_alg_in_blk),
    .aes_alg_out_blk    (aes_alg_out_blk),
    .aes_op_in_progress (aes_op_in_progress),
    .aes_alg_done       (aes_alg_done)
  );

  // Stand-in core transform: real FIPS-197 answers for the two known vectors, otherwise a
  // key/mode/direction dependent scramble so wrong keys, sizes or directions show up.
  function automatic logic [127:0] core_fn(input logic [255:0] key, input logic a256,
                                           input logic dec, input logic [127:0] blk);
    if (key == K_FIPS && !a256 && !dec && blk == PT) return CT;
    if (key == K_FIPS && !a256 && dec && blk == CT) return PT;
    return blk ^ key[255:128] ^ (a256 ? key[127:0] : 128'h0) ^
           (dec ? 128'h5a5a_0f0f_1234_5678_9abc_def0_a5a5_c3c3
                : 128'h3c3c_f0f0_8765_4321_0fed_cba9_5a5a_1e1e);
  endfunction

  int unsigned  k_cnt = 0, o_cnt = 0, en_key_cnt = 0;
  logic         busy_k = 1'b0, busy_o = 1'b0, core_a256 = 1'b0, core_bad = 1'b0, op_dec = 1'b0;
  logic [255:0] core_key = '0;
  logic [127:0] op_in = '0;

  always @(posedge clk) begin
    aes_alg_done <= 1'b0;
    if (aes_alg_en_key) begin
      core_key   <= aes_alg_key;
      core_a256  <= aes256_mode;
      core_bad   <= (aes128_mode == aes256_mode);
      busy_k     <= 1'b1;
      k_cnt      <= KLAT;
      en_key_cnt <= en_key_cnt + 1;
    end else if (busy_k) begin
      if (k_cnt == 1) begin
        busy_k       <= 1'b0;
        aes_alg_done <= 1'b1;
      end
      k_cnt <= k_cnt - 1;
    end
    if (aes_alg_en_cipher || aes_alg_en_decipher) begin
      op_dec <= aes_alg_en_decipher;
      op_in  <= aes_alg_in_blk;
      busy_o <= 1'b1;
      o_cnt  <= OLAT;
    end else if (busy_o) begin
      if (o_cnt == 1) begin
        busy_o          <= 1'b0;
        aes_alg_done    <= 1'b1;
        aes_alg_out_blk <= core_fn(core_key, core_a256, op_dec, op_in) ^
                           (core_bad ? 128'hdead : 128'h0);
      end
      o_cnt <= o_cnt - 1;
    end
  end

  assign aes_op_in_progress = busy_k || busy_o;

  int viol = 0;
  always @(negedge clk) begin
    #2;
    if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 ||
        (aes_alg_en_cipher && aes_alg_en_decipher)) viol <= viol + 1;
  end

  typedef struct {
    int           idx;
    logic         dec;
    logic         a256;
    logic [255:0] key;
    logic [KB-1:0] id;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    int           idx;
    logic [127:0] blk;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int idx, input logic dec, input logic a256,
                              input logic [255:0] key, input logic [KB-1:0] id,
                              input logic [127:0] blk, input logic [127:0] exp);
    vec_t v;
    v.idx = idx; v.dec = dec; v.a256 = a256; v.key = key; v.id = id; v.blk = blk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    $display("FAIL %s: got no DUT event within the cycle budget, required one", name);
  endtask

  task automatic push_exp(input int idx, input logic [127:0] blk);
    exp_t e;
    e.idx = idx;
    e.blk = blk;
    sb.push_back(e);
  endtask

  task automatic drive_slot(input vec_t v);
    req_decrypt[v.idx]            = v.dec;
    req_aes256[v.idx]             = v.a256;
    req_key[v.idx*256 +: 256]     = v.key;
    req_key_id[v.idx*KB +: KB]    = v.id;
    req_blk[v.idx*128 +: 128]     = v.blk;
    req_valid[v.idx]              = 1'b1;
  endtask

  // Called at a negedge after driving; samples 1 time unit later each cycle.
  task automatic wait_grant(input string name, input logic [1:0] exp_mask, output int g);
    g = -1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) fail_timeout(name);
    else check(name, {254'd0, req_ready}, {254'd0, exp_mask});
  endtask

  task automatic wait_rsp(input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_timeout(name);
      return;
    end
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: got unexpected rsp_valid %b, required no response", name, rsp_valid);
      rsp_ready = rsp_valid;
      @(negedge clk);
      rsp_ready = 2'b00;
      return;
    end
    e = sb.pop_front();
    check({name, "_vld"}, {254'd0, rsp_valid}, 256'(2'b01 << e.idx));
    check({name, "_blk"}, {128'd0, rsp_blk}, {128'd0, e.blk});
    rsp_ready        = 2'b00;
    rsp_ready[e.idx] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic run_req(input string name, input vec_t v);
    int g;
    @(negedge clk);
    drive_slot(v);
    wait_grant({name, "_gnt"}, 2'b01 << v.idx, g);
    if (g >= 0) push_exp(v.idx, v.exp);
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    if (g >= 0) wait_rsp(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {247'd0, req_ready, rsp_valid, aes_alg_en_key, aes_alg_en_cipher,
          aes_alg_en_decipher, aes128_mode, aes256_mode}, 256'd0);
    check({name, "_key"}, aes_alg_key, 256'd0);
    check({name, "_blk"}, {rsp_blk, aes_alg_in_blk}, 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, v;
    int   g, k0, bad;
    logic [127:0] hold_blk;

    vecs[0] = mk(0, 1'b0, 1'b0, K_FIPS, 4'd1, PT, CT);
    vecs[1] = mk(1, 1'b1, 1'b0, K_FIPS, 4'd1, CT, PT);
    vecs[2] = mk(0, 1'b0, 1'b1, K2, 4'd2, 128'h3243f6a8885a308d313198a2e0370734,
                 core_fn(K2, 1'b1, 1'b0, 128'h3243f6a8885a308d313198a2e0370734));
    vecs[3] = mk(1, 1'b1, 1'b1, K2, 4'd2, 128'hdeadbeef0badf00dcafebabe12345678,
                 core_fn(K2, 1'b1, 1'b1, 128'hdeadbeef0badf00dcafebabe12345678));
    vecs[4] = mk(1, 1'b0, 1'b0, K3, 4'd5, 128'h6bc1bee22e409f96e93d7e117393172a,
                 core_fn(K3, 1'b0, 1'b0, 128'h6bc1bee22e409f96e93d7e117393172a));
    vecs[5] = mk(0, 1'b1, 1'b0, K3, 4'd5, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                 core_fn(K3, 1'b0, 1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51));

    reset = 1'b1; req_valid = '0; req_decrypt = '0; req_aes256 = '0; req_key = '0;
    req_key_id = '0; req_blk = '0; rsp_ready = '0; key_flush = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs_zero("idle");

    for (int i = 0; i < 6; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Same key tag twice in a row, then again with a flush in between.
    k0 = en_key_cnt;
    v = mk(0, 1'b0, 1'b0, K4, 4'd3, 128'h0123456789abcdef0011223344556677,
           core_fn(K4, 1'b0, 1'b0, 128'h0123456789abcdef0011223344556677));
    vb = mk(1, 1'b1, 1'b0, K4, 4'd3, 128'h8899aabbccddeeff0123456789abcdef,
            core_fn(K4, 1'b0, 1'b1, 128'h8899aabbccddeeff0123456789abcdef));
    run_req("kid3_a", v);
    run_req("kid3_b", vb);
    check("kid3_expansions", 256'(en_key_cnt - k0), 256'(SAME_ID_EXPANSIONS));
    @(negedge clk); key_flush = 1'b1;
    @(negedge clk); key_flush = 1'b0;
    k0 = en_key_cnt;
    run_req("kid3_c", v);
    @(negedge clk); key_flush = 1'b1;
    @(negedge clk); key_flush = 1'b0;
    run_req("kid3_d", vb);
    check("kid3_flush_expansions", 256'(en_key_cnt - k0), 256'd2);

    // Both requesters continuously valid from the first cycle after reset.
    va = vecs[0];
    vb = vecs[2];
    vb.idx = 1;
    do_reset();
    drive_slot(va);
    drive_slot(vb);
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr%0d", k), 2'b01 << (k % 2), g);
      if (g < 0) break;
      push_exp(k % 2, (k % 2 == 0) ? va.exp : vb.exp);
      wait_rsp($sformatf("rr%0d_rsp", k));
    end
    req_valid = 2'b00;

    // Back-pressure: result held for 10 cycles while the other requester waits.
    @(negedge clk);
    drive_slot(vecs[0]);
    wait_grant("hold_gnt", 2'b01, g);
    if (g >= 0) push_exp(0, vecs[0].exp);
    @(negedge clk);
    req_valid[0] = 1'b0;
    g = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) begin
        g = 0;
        break;
      end
    end
    if (g < 0) begin
      fail_timeout("hold_rsp_wait");
      sb.delete();
    end else begin
      hold_blk = rsp_blk;
      drive_slot(vecs[3]);
      bad = 0;
      repeat (10) begin
        @(negedge clk);
        #1;
        if (rsp_blk !== hold_blk || req_ready != 2'b00 || rsp_valid != 2'b01) bad++;
      end
      check("hold_stable", 256'(bad), 256'd0);
      wait_rsp("hold_rsp");
      wait_grant("hold_next_gnt", 2'b10, g);
      if (g >= 0) push_exp(1, vecs[3].exp);
      @(negedge clk);
      req_valid[1] = 1'b0;
      if (g >= 0) wait_rsp("hold_next_rsp");
    end

    // Reset while the core is expanding a key.
    do_reset();
    drive_slot(vecs[0]);
    wait_grant("krst_gnt", 2'b01, g);
    @(negedge clk);
    req_valid[0] = 1'b0;
    g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (aes_op_in_progress) begin
        g = 0;
        break;
      end
    end
    if (g < 0) fail_timeout("krst_busy");
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("krst");
    reset = 1'b0;
    sb.delete();
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) bad++;
    end
    check("krst_no_rsp", 256'(bad), 256'd0);
    k0 = en_key_cnt;
    run_req("krst_after", vecs[0]);
    check("krst_reexpand", 256'(en_key_cnt - k0), 256'd1);

    repeat (2) @(negedge clk);
    check("onehot_monitor", 256'(viol), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
